blk_com_fifo_rd_burst: RTL and testbench
========================================

# blk_com_fifo_rd_burst

Burst read controller that sits directly downstream of the common 256x32 synchronous FIFO. It decides when to drain the FIFO and issues `rd_en` against the FIFO's one-cycle read latency. Words are delivered as framed bursts (SOP/EOP) on a valid/ready stream through a 2-entry skid buffer. Bursts start when the fill level reaches a threshold, or when a timeout expires on a partly filled FIFO.

## Interface
- `DW`, 32: data width, matches FIFO `dout`.
- `CW`, 8: width of FIFO `data_count`.
- `BURST_TH`, 16: fill threshold and maximum burst length, range 1..256.
- `TIMEOUT`, 255: number of idle cycles with a non-empty FIFO before a short burst is forced, range 1..65535.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fifo_dout`  in  DW  FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_data_count`  in  CW  FIFO fill level.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `m_data`  out  DW  output word.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_sop`  out  1  first word of burst, qualified by `m_valid`.
- `m_eop`  out  1  last word of burst, qualified by `m_valid`.
- `busy`  out  1  high while state is not IDLE.

## Operation
- Effective fill `lvl = fifo_full ? 2**CW : fifo_data_count`. A 256-deep FIFO reports `data_count = 0` when full.
- State machine has two states: IDLE and BURST.
  - IDLE -> BURST, with `len = BURST_TH`, when `lvl >= BURST_TH`.
  - IDLE -> BURST, with `len = lvl`, when `!fifo_empty` and `idle_tmr == TIMEOUT`.
  - `lvl` is snapshotted in the same cycle as the transition.
  - BURST -> IDLE on the pop of the EOP word (`m_valid & m_ready & m_eop`).
- `idle_tmr` increments in IDLE while `!fifo_empty` and saturates at TIMEOUT. It clears when `fifo_empty`, in BURST, and on reset.
- Issue counter `rem` loads `len` on entry to BURST and decrements on each `fifo_rd_en`.
- Read strobe: `fifo_rd_en = BURST & rem != 0 & !fifo_empty & (2 - occ - inflight + pop) > 0`.
  - `occ` is skid buffer occupancy, 0..2.
  - `inflight` is `fifo_rd_en` registered, 0..1.
  - `pop = m_valid & m_ready`.
  - This guarantees the skid buffer never overflows and never drops a word.
- Captured words carry tags. SOP is the first read of the burst. EOP is the read issued when `rem == 1`. Both tags travel with the data through the skid buffer.
- The skid buffer is FIFO-ordered and 2 entries deep. Output comes from the head entry. `m_data`, `m_sop` and `m_eop` hold stable while `m_valid & !m_ready`.
- Words in the FIFO beyond `len` stay untouched. If `fifo_empty` rises mid-burst, which should not happen since `len <= lvl`, reads stall until it falls.

## Timing
- Reset (async assert, sync release): state IDLE, `fifo_rd_en = 0`, `m_valid = 0`, `m_data = 0`, `m_sop = 0`, `m_eop = 0`, `busy = 0`, `occ = 0`, `inflight = 0`, `rem = 0`, `idle_tmr = 0`.
- Reset mid-burst abandons the burst. Words already read from the FIFO are lost, and the FIFO is not rewound.
- `fifo_rd_en` is combinational from registered state and `m_ready`.
- Latency from threshold to output:
  - Cycle N: IDLE and `lvl >= BURST_TH`.
  - Cycle N+1: BURST, `busy = 1`, first `fifo_rd_en`.
  - Cycle N+2: `fifo_dout` valid, written into the skid buffer at the end of the cycle.
  - Cycle N+3: `m_valid = 1` with `m_sop = 1`.
- Throughput is one word per cycle while `m_ready = 1`. A burst of L words with no backpressure takes L consecutive `fifo_rd_en` cycles and L consecutive `m_valid` cycles.
- Next burst: IDLE is re-entered in the cycle after the EOP pop. The earliest next `fifo_rd_en` is 2 cycles after the EOP pop.
- The timeout burst starts in the cycle after `idle_tmr` reaches TIMEOUT, i.e. after TIMEOUT+1 non-empty idle cycles.
- With `BURST_TH = 1`, SOP and EOP are asserted on the same word.

## Test plan
- Reset check: assert `rst_n = 0` with random inputs -> all outputs 0, and stay 0 until release. After release with `fifo_empty = 1` -> `fifo_rd_en` stays 0 and `busy` stays 0.
- Threshold burst: preload 20 words (0..19), `m_ready = 1`.
  - Expect 16 contiguous `fifo_rd_en` pulses.
  - Expect `m_data` 0..15 on consecutive cycles, with SOP on 0 and EOP on 15.
  - Afterwards `busy = 0`; words 16..19 remain in the FIFO.
- Timeout burst: preload 3 words, TIMEOUT = 255 -> no read for 256 cycles, then a 3-word burst with SOP on the first word and EOP on the third.
- Backpressure: 16-word burst with `m_ready` random at 30% -> output sequence exact, no loss and no duplication. `occ + inflight` never exceeds 2. Data is held stable while stalled.
- Full FIFO: 256 words loaded, `fifo_full = 1`, `data_count = 0` -> burst of 16 starts. Sixteen back-to-back bursts then drain the FIFO in order 0..255.
- Reset mid-burst: assert `rst_n` after 5 words popped -> `m_valid` and `fifo_rd_en` go 0 immediately. After release, the next burst starts with SOP on the word then at the FIFO head.

Source files
------------

// File: rtl/blk_com_fifo_rd_burst.sv
// Burst read controller behind a 256x32 synchronous FIFO: drains SOP/EOP-framed
// bursts on threshold or idle timeout, through a 2-entry skid buffer.
module blk_com_fifo_rd_burst #(
  parameter int unsigned DW       = 32,
  parameter int unsigned CW       = 8,
  parameter int unsigned BURST_TH = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [CW-1:0] fifo_data_count,
  output logic          fifo_rd_en,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sop,
  output logic          m_eop,
  output logic          busy
);

  localparam logic [CW:0] TH  = (CW+1)'(BURST_TH);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [CW:0]   lvl, len, rem;
  logic [15:0]   idle_tmr;
  logic [1:0]    occ;
  logic          inflight, infl_sop, infl_eop, sop_pend;
  logic          pop, push;
  // Skid entries are {sop, eop, data}; ent0 is the head.
  logic [DW+1:0] ent0, ent1, ent_new;

  // A full 256-deep FIFO reports data_count == 0.
  assign lvl     = fifo_full ? {1'b1, {CW{1'b0}}} : {1'b0, fifo_data_count};
  assign pop     = (occ != 2'd0) & m_ready;
  assign push    = inflight;
  assign ent_new = {infl_sop, infl_eop, fifo_dout};

  always_comb begin
    state_nxt  = state;
    len        = TH;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (lvl >= TH) begin
          state_nxt = BURST;
          len       = TH;
        end else if (!fifo_empty && idle_tmr == TMO) begin
          state_nxt = BURST;
          len       = lvl;
        end
      end
      BURST: begin
        if (pop && ent0[DW]) state_nxt = IDLE;
        // Free slots counted after this cycle's pop, minus the word already in flight.
        fifo_rd_en = (rem != '0) && !fifo_empty &&
                     ((3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop)));
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idle_tmr <= '0;
      rem      <= '0;
      sop_pend <= 1'b0;
      inflight <= 1'b0;
      infl_sop <= 1'b0;
      infl_eop <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == BURST || fifo_empty) idle_tmr <= '0;
      else if (idle_tmr != TMO)        idle_tmr <= idle_tmr + 16'd1;
      if (state == IDLE && state_nxt == BURST) begin
        rem      <= len;
        sop_pend <= 1'b1;
      end else if (fifo_rd_en) begin
        rem      <= rem - (CW+1)'(1);
        sop_pend <= 1'b0;
      end
      inflight <= fifo_rd_en;
      infl_sop <= fifo_rd_en & sop_pend;
      infl_eop <= fifo_rd_en & (rem == (CW+1)'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      occ <= occ + 2'(push) - 2'(pop);
      if (pop) begin
        if (occ == 2'd2) ent0 <= ent1;
        else if (push)   ent0 <= ent_new;
      end else if (occ == 2'd0 && push) begin
        ent0 <= ent_new;
      end
      if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) ent1 <= ent_new;
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = ent0[DW-1:0];
  assign m_sop   = m_valid & ent0[DW+1];
  assign m_eop   = m_valid & ent0[DW];
  assign busy    = (state == BURST);

endmodule

// File: tb/tb_blk_com_fifo_rd_burst.sv
// Self-checking bench for blk_com_fifo_rd_burst: behavioural FIFO, stream scoreboard
// checked every cycle, and directed burst scenarios with hand-computed timing.
module tb_blk_com_fifo_rd_burst;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] fifo_dout, dout_q = '0, r_dout;
  logic          fifo_empty, fifo_full, fifo_rd_en;
  logic [CW-1:0] fifo_data_count, r_count;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_sop, m_eop, busy;
  logic          use_rnd, r_empty, r_full;

  always #5 clk = ~clk;

  // FIFO model: word value equals its absolute write index.
  logic [DW-1:0] mem [256];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  int unsigned   fcount;

  assign fcount          = wr_ptr - rd_ptr;
  assign fifo_empty      = use_rnd ? r_empty : (fcount == 0);
  assign fifo_full       = use_rnd ? r_full  : (fcount == 256);
  assign fifo_data_count = use_rnd ? r_count : CW'(fcount);
  assign fifo_dout       = use_rnd ? r_dout  : dout_q;

  always @(posedge clk) begin
    if (fifo_rd_en && fcount != 0 && !use_rnd) begin
      dout_q <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  blk_com_fifo_rd_burst #(.DW(32), .CW(8), .BURST_TH(16), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_data_count(fifo_data_count), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop),
    .m_eop(m_eop), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int unsigned exp_word = 0;
  int exp_len = 16;
  bit done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 256] = wr_ptr;
      wr_ptr++;
    end
  endtask

  // Waits for a burst to start and end; cycle 0 is the current cycle.
  task automatic wait_burst(input bit rnd, output int t_rd, output int n_rd,
                            output int t_val, output int n_pop, output bit contig);
    int c = 0;
    int last_rd = -1;
    bit seen = 0;
    t_rd = -1; t_val = -1; n_rd = 0; n_pop = 0; contig = 1;
    while (c < 3000) begin
      @(negedge clk);
      if (busy) seen = 1;
      if (fifo_rd_en) begin
        if (t_rd < 0) t_rd = c;
        else if (last_rd != c - 1) contig = 0;
        last_rd = c;
        n_rd++;
      end
      if (m_valid && t_val < 0) t_val = c;
      if (m_valid && m_ready) n_pop++;
      if (seen && !busy) break;
      c++;
      @(posedge clk); #1;
      m_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
    check("burst_completes", 64'(seen && !busy), 1);
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b0; use_rnd = 1'b1;
    r_empty = 1'b0; r_full = 1'b0; r_count = '0; r_dout = '0;
    fork
      begin : monitor
        int cyc = 0;
        int issued = 0, popped = 0, bidx = 0;
        bit prev_stall = 0;
        logic [DW-1:0] prev_data = '0;
        logic prev_sop = 0, prev_eop = 0;
        while (!done) begin
          @(negedge clk);
          cyc++;
          if (cyc > 20000) begin
            $display("FAIL watchdog: actual %0d cycles required below 20000", cyc);
            $fatal(1, "watchdog expired");
          end
          if (!rst_n) begin
            issued = 0; popped = 0; bidx = 0; prev_stall = 0;
          end else begin
            check("outstanding_over_2", 64'((issued - popped) > 2), 0);
            if (m_valid) check("valid_without_busy", busy, 1);
            if (fifo_rd_en) check("rd_on_empty_fifo", 64'(fcount != 0), 1);
            if (prev_stall) begin
              check("hold_valid", m_valid, 1);
              check("hold_data", m_data, prev_data);
              check("hold_sop", m_sop, prev_sop);
              check("hold_eop", m_eop, prev_eop);
            end
            if (m_valid && m_ready) begin
              check("data", m_data, exp_word);
              check("sop", m_sop, 64'(bidx == 0));
              check("eop", m_eop, 64'(bidx == exp_len - 1));
              exp_word++;
              bidx = (bidx == exp_len - 1) ? 0 : bidx + 1;
            end
            issued += int'(fifo_rd_en);
            popped += int'(m_valid && m_ready);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data; prev_sop = m_sop; prev_eop = m_eop;
          end
        end
      end
      begin : stimulus
        int t_rd, n_rd, t_val, n_pop, bad, pops;
        bit contig;
        // Reset with random inputs
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          r_empty = 1'($urandom_range(0, 1)); r_full = 1'($urandom_range(0, 1));
          r_count = CW'($urandom); r_dout = $urandom; m_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("rst_rd_en", fifo_rd_en, 0);
          check("rst_valid", m_valid, 0);
          check("rst_data", m_data, 0);
          check("rst_sop", m_sop, 0);
          check("rst_eop", m_eop, 0);
          check("rst_busy", busy, 0);
        end
        @(posedge clk); #1;
        use_rnd = 1'b0; m_ready = 1'b1; rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
          @(negedge clk);
          if (fifo_rd_en || busy) bad++;
        end
        check("empty_idle_activity", bad, 0);

        // Threshold burst: 20 words, 16 taken
        exp_len = 16;
        @(posedge clk); #1; load(20);
        wait_burst(0, t_rd, n_rd, t_val, n_pop, contig);
        check("th_first_rd_cycle", t_rd, 1);
        check("th_rd_count", n_rd, 16);
        check("th_rd_contig", contig, 1);
        check("th_first_valid_cycle", t_val, 3);
        check("th_pop_count", n_pop, 16);
        check("th_left_in_fifo", fcount, 4);
        check("th_busy_after", busy, 0);

        // Leftover 4 words leave by timeout
        exp_len = 4;
        wait_burst(0, t_rd, n_rd, t_val, n_pop, contig);
        check("rem_first_rd_cycle", t_rd, 255);
        check("rem_rd_count", n_rd, 4);

        // Timeout burst: 3 words
        exp_len = 3;
        @(posedge clk); #1; load(3);
        wait_burst(0, t_rd, n_rd, t_val, n_pop, contig);
        check("to_first_rd_cycle", t_rd, 256);
        check("to_rd_count", n_rd, 3);
        check("to_pop_count", n_pop, 3);
        check("to_fifo_empty", fcount, 0);

        // Backpressure: 30% ready
        exp_len = 16;
        @(posedge clk); #1; load(16);
        wait_burst(1, t_rd, n_rd, t_val, n_pop, contig);
        check("bp_first_rd_cycle", t_rd, 1);
        check("bp_rd_count", n_rd, 16);
        check("bp_pop_count", n_pop, 16);
        check("bp_fifo_empty", fcount, 0);
        @(posedge clk); #1; m_ready = 1'b1;

        // Full FIFO drained by sixteen bursts
        exp_len = 16;
        load(256);
        #1;
        check("full_flag", fifo_full, 1);
        check("full_count_wraps", fifo_data_count, 0);
        for (int b = 0; b < 16; b++) begin
          wait_burst(0, t_rd, n_rd, t_val, n_pop, contig);
          if (b == 0) check("full_first_rd_cycle", t_rd, 1);
          check("full_rd_count", n_rd, 16);
          check("full_rd_contig", contig, 1);
        end
        check("full_drained", fcount, 0);
        check("full_all_seen", exp_word, wr_ptr);

        // Reset after 5 pops
        exp_len = 16;
        @(posedge clk); #1; load(20);
        pops = 0;
        for (int i = 0; i < 200 && pops < 5; i++) begin
          @(negedge clk);
          if (m_valid && m_ready) pops++;
        end
        check("mr_pops_before_reset", pops, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mr_valid_low", m_valid, 0);
        check("mr_rd_en_low", fifo_rd_en, 0);
        check("mr_busy_low", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("mr_words_left", fcount, 13);
        exp_word = rd_ptr;
        exp_len = 13;
        rst_n = 1'b1;
        wait_burst(0, t_rd, n_rd, t_val, n_pop, contig);
        check("mr_first_rd_cycle", t_rd, 256);
        check("mr_rd_count", n_rd, 13);
        check("mr_fifo_empty", fcount, 0);
        repeat (2) @(negedge clk);
        done = 1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
